// File: rtl/mips_mult_div.sv
// Iterative MIPS multiply/divide unit (MULT/MULTU/DIV/DIVU).
// Shift-add multiply and restoring divide, one bit per clock, into HI/LO.
module mips_mult_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               div_q, div_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;

    // Next-state, iteration step and result fix-up
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        prod      = '0;

        a_neg = op[0] & operand_a[WIDTH-1];
        b_neg = op[0] & operand_b[WIDTH-1];
        mag_a = a_neg ? -operand_a : operand_a;
        mag_b = b_neg ? -operand_b : operand_b;

        // acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // acc = {partial remainder, dividend bits / quotient bits}
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}
                  - {1'b0, m_q};
        div_next  = div_trial[WIDTH]
                  ? {acc_q[2*WIDTH-2:0], 1'b0}
                  : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d     = op[1];
                    cnt_d     = '0;
                    neg_d     = a_neg ^ b_neg;
                    zero_d    = op[1] & (operand_b == '0);
                    if (op[1]) begin
                        m_d       = mag_b;
                        acc_d     = {{WIDTH{1'b0}}, mag_a};
                        rem_neg_d = a_neg;
                    end else begin
                        m_d       = mag_a;
                        acc_d     = {{WIDTH{1'b0}}, mag_b};
                        rem_neg_d = 1'b0;
                    end
                    if (op[1] && operand_b == '0) begin
                        // Result is preloaded so FINISH passes it through
                        acc_d     = {operand_a, {WIDTH{1'b1}}};
                        neg_d     = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = S_FINISH;
                    end else begin
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                dbz_d   = zero_q;
                state_d = S_IDLE;
                if (div_q) begin
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH]
                                     : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    prod = neg_q ? -acc_q : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_mult_div.sv
// Bench for mips_mult_div: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed HI/LO values.
module tb_mips_mult_div;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_pass = 0;
    int n_total = 0;

    mips_mult_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference results from plain 64-bit arithmetic
    function automatic void calc(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] rh,
                                 output logic [31:0] rl, output logic rz);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rz = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                rh = p[63:32]; rl = p[31:0];
            end
            2'd1: begin
                p = 64'(sa * sb);
                rh = p[63:32]; rl = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    rz = 1'b1; rh = a; rl = 32'hFFFF_FFFF;
                end else if (o == 2'd2) begin
                    rl = a / b; rh = a % b;
                end else begin
                    sq = sa / sb; sr = sa % sb;
                    rl = sq[31:0]; rh = sr[31:0];
                end
            end
        endcase
    endfunction

    // Model: remaining busy cycles, pending result, architectural HI/LO
    int          m_rem = 0;
    logic        m_done = 0, m_dbz = 0, p_dbz = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0; m_done = 0; m_hi = 0; m_lo = 0; m_dbz = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1; m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
                end
            end else if (start) begin
                calc(op, operand_a, operand_b, p_hi, p_lo, p_dbz);
                m_rem = p_dbz ? 1 : 33;
            end
        end
    end

    logic cmp_en = 0;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_rem > 0));
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_hi", 64'(hi), 64'(m_hi));
            chk("cyc_lo", 64'(lo), 64'(m_lo));
            chk("cyc_dbz", 64'(div_by_zero), 64'(m_dbz));
        end
    end

    // Pulse start for one cycle; returns at the negedge after the accept edge
    task automatic go(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lat,
                             input logic [31:0] eh, input logic [31:0] el,
                             input logic ez);
        int n;
        int nb;
        n = 0;
        nb = busy ? 1 : 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
        if (!done) chk({name, "_timeout"}, 64'(0), 64'(1));
        chk({name, "_lat"}, 64'(n), 64'(lat));
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
        chk({name, "_dbz"}, 64'(div_by_zero), 64'(ez));
        if (lat >= 28) chk({name, "_busycyc"}, 64'(nb), 64'(lat));
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        go(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        chk("multu_done_pulse", 64'(done), 64'(0));

        go(2'd1, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        go(2'd1, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min", 33, 32'h4000_0000, 32'h0, 1'b0);

        go(2'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        go(2'd2, 32'd100, 32'd7);
        wait_done("divu", 33, 32'd2, 32'd14, 1'b0);
        go(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 33, 32'h0, 32'h8000_0000, 1'b0);
        go(2'd3, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_negb", 33, 32'd1, 32'hFFFF_FFFD, 1'b0);

        go(2'd2, 32'd100, 32'd0);
        wait_done("divu_zero", 1, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        go(2'd3, 32'hFFFF_FFF0, 32'd0);
        wait_done("div_zero", 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        go(2'd0, 32'd2, 32'd3);
        wait_done("multu_clr", 33, 32'd0, 32'd6, 1'b0);

        // start re-pulsed while busy must be ignored
        go(2'd0, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        go(2'd2, 32'd100, 32'd7);
        wait_done("ignore", 28, 32'd0, 32'd42, 1'b0);
        // start in the done cycle is accepted at the next edge
        go(2'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        wait_done("b2b", 33, 32'd0, 32'd6, 1'b0);

        // asynchronous reset in the middle of RUN
        go(2'd0, 32'd6, 32'd7);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_hi", 64'(hi), 64'(0));
        chk("mid_rst_lo", 64'(lo), 64'(0));
        chk("mid_rst_dbz", 64'(div_by_zero), 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_idle", 64'(busy), 64'(0));
        go(2'd0, 32'd2, 32'd2);
        wait_done("after_rst", 33, 32'd0, 32'd4, 1'b0);

        repeat (3) @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
